// File: rtl/elevator_controller_pkg.sv
// Shared definitions for the elevator scheduler: state encodings (also
// decoded by the floor display logic) and small elaboration helpers.
package elevator_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_controller_call_latch.sv
// Call latch: edge-detects the debounced floor-call levels, holds unserved
// calls until the car stops at that floor, and reports whether any call
// lies above or below the car.
module elevator_controller_call_latch
  import elevator_controller_pkg::*;
#(
  parameter int FLOORS = 4,
  parameter int FW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] i_call_btn,
  input  logic [FLOORS-1:0] i_block_mask,
  input  logic [FLOORS-1:0] i_clr_mask,
  input  logic [FW-1:0]     i_cur_floor,
  output logic [FLOORS-1:0] o_pending,
  output logic [FLOORS-1:0] o_rise,
  output logic              o_ahead_up,
  output logic              o_ahead_dn
);

  logic [FLOORS-1:0] r_prev_btn;
  logic [FLOORS-1:0] r_pending;

  assign o_rise    = i_call_btn & ~r_prev_btn;
  assign o_pending = r_pending;

  // Latch new rises (except the blocked floor); the stop clear wins over a same-edge rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_btn <= '0;
      r_pending  <= '0;
    end else begin
      r_prev_btn <= i_call_btn;
      r_pending  <= (r_pending | (o_rise & ~i_block_mask)) & ~i_clr_mask;
    end
  end

  // Any latched call strictly above / below the car
  always_comb begin
    o_ahead_up = 1'b0;
    o_ahead_dn = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (r_pending[i] && (i > int'(i_cur_floor))) o_ahead_up = 1'b1;
      if (r_pending[i] && (i < int'(i_cur_floor))) o_ahead_dn = 1'b1;
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// Single-car elevator scheduler with a collective up/down sweep. Owns the
// motion/door FSM and the shared travel/dwell timer; call bookkeeping lives
// in the call latch.
module elevator_controller
  import elevator_controller_pkg::*;
#(
  parameter int  FLOORS      = 4,
  parameter int  MOVE_CYCLES = 100000,
  parameter int  DOOR_CYCLES = 200000,
  localparam int FW          = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] call_btn,
  output logic [FW-1:0]     cur_floor,
  output logic [FLOORS-1:0] pending,
  output logic              moving,
  output logic              dir_up,
  output logic              door_open
);

  localparam int TW = $clog2(max2(MOVE_CYCLES, DOOR_CYCLES));
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);

  state_t            r_state;
  logic              r_dir_up;
  logic [FW-1:0]     r_floor;
  logic [TW-1:0]     r_timer;

  state_t            w_state_nxt;
  logic              w_dir_nxt;
  logic [FW-1:0]     w_floor_nxt;
  logic [TW-1:0]     w_timer_nxt;
  logic [FLOORS-1:0] w_clr_mask;
  logic [FLOORS-1:0] w_block_mask;
  logic [FLOORS-1:0] w_pending;
  logic [FLOORS-1:0] w_rise;
  logic              w_ahead_up;
  logic              w_ahead_dn;
  logic              w_rise_here;
  logic [FW-1:0]     w_step_floor;
  logic              w_stop_here;
  logic              w_at_end;
  logic              w_go_fwd;
  logic              w_go_rev;

  // A press at the car's own floor opens/holds the door instead of latching,
  // but only while the car is parked there.
  assign w_block_mask = ((r_state == ST_IDLE) || (r_state == ST_DOOR_OPEN)) ?
                        (FLOORS'(1) << r_floor) : '0;

  elevator_controller_call_latch #(
    .FLOORS (FLOORS),
    .FW     (FW)
  ) u_call_latch (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_call_btn   (call_btn),
    .i_block_mask (w_block_mask),
    .i_clr_mask   (w_clr_mask),
    .i_cur_floor  (r_floor),
    .o_pending    (w_pending),
    .o_rise       (w_rise),
    .o_ahead_up   (w_ahead_up),
    .o_ahead_dn   (w_ahead_dn)
  );

  assign w_rise_here  = w_rise[r_floor];
  assign w_step_floor = (r_state == ST_MOVE_UP) ? (r_floor + FW'(1)) : (r_floor - FW'(1));
  // A rise at the arrival floor on the arrival edge still takes the stop
  assign w_stop_here  = w_pending[w_step_floor] | w_rise[w_step_floor];
  assign w_at_end     = (r_state == ST_MOVE_UP) ? (w_step_floor == TOP_FLOOR) :
                                                  (w_step_floor == '0);
  assign w_go_fwd     = r_dir_up ? w_ahead_up : w_ahead_dn;
  assign w_go_rev     = r_dir_up ? w_ahead_dn : w_ahead_up;

  // State, direction, floor and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_dir_up <= 1'b1;
      r_floor  <= '0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir_up <= w_dir_nxt;
      r_floor  <= w_floor_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  // Sweep policy: keep going the same way while calls remain ahead, else reverse
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir_up;
    w_floor_nxt = r_floor;
    w_timer_nxt = r_timer;
    w_clr_mask  = '0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (w_rise_here) begin
          w_state_nxt = ST_DOOR_OPEN;
        end else if (w_go_fwd) begin
          w_state_nxt = r_dir_up ? ST_MOVE_UP : ST_MOVE_DOWN;
        end else if (w_go_rev) begin
          w_dir_nxt   = ~r_dir_up;
          w_state_nxt = r_dir_up ? ST_MOVE_DOWN : ST_MOVE_UP;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (r_timer == MOVE_LAST) begin
          w_timer_nxt = '0;
          w_floor_nxt = w_step_floor;
          if (w_stop_here) begin
            w_clr_mask  = FLOORS'(1) << w_step_floor;
            w_state_nxt = ST_DOOR_OPEN;
          end else if (w_at_end) begin
            // Defensive: never run past the shaft ends
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_DOOR_OPEN: begin
        if (w_rise_here) begin
          w_timer_nxt = '0;
        end else if (r_timer == DOOR_LAST) begin
          w_timer_nxt = '0;
          if (w_go_fwd) begin
            w_state_nxt = r_dir_up ? ST_MOVE_UP : ST_MOVE_DOWN;
          end else if (w_go_rev) begin
            w_dir_nxt   = ~r_dir_up;
            w_state_nxt = r_dir_up ? ST_MOVE_DOWN : ST_MOVE_UP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Motion and door outputs decoded from state
  always_comb begin
    moving    = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
    door_open = (r_state == ST_DOOR_OPEN);
  end

  assign cur_floor = r_floor;
  assign dir_up    = r_dir_up;
  assign pending   = w_pending;

endmodule
